// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the iteration-counter width helper.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX
  } state_e;

  // Counter must hold the value WIDTH itself.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the mul/div datapath.
// Multiply: conditional add of the multiplicand, then a right shift of
//           {carry, acc}; bit_out is the bit shifted into the low register.
// Divide:   restoring step; {acc, low_bit} is trial-subtracted by the
//           divisor and bit_out is the quotient bit.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] opnd,
  input  logic             low_bit,
  input  logic             is_div,
  output logic [WIDTH-1:0] acc_nxt,
  output logic             bit_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] sh;
  logic           fits;

  always_comb begin
    sum  = {1'b0, acc} + (low_bit ? {1'b0, opnd} : '0);
    sh   = {acc, low_bit};
    fits = (sh >= {1'b0, opnd});
    if (is_div) begin
      acc_nxt = fits ? WIDTH'(sh - {1'b0, opnd}) : sh[WIDTH-1:0];
      bit_out = fits;
    end else begin
      acc_nxt = sum[WIDTH:1];
      bit_out = sum[0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Optional feature: define MULDIV_FAST_MUL_EN for single-cycle multiplies.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = cnt_w(WIDTH);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] acc, acc_nxt, low, low_nxt, opnd, opnd_nxt;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic             is_div, is_div_nxt, neg_q, neg_q_nxt, neg_r, neg_r_nxt;
  logic             done_nxt;

  logic             signed_op, op_div;
  logic [WIDTH-1:0] a_abs, b_abs, step_acc, q_fix, r_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic             step_low, step_bit;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] prod;
`endif

  assign busy     = (state != ST_IDLE);
  // Divide shifts the dividend out of the top of low; multiply consumes
  // the multiplier from the bottom.
  assign step_low = is_div ? low[WIDTH-1] : low[0];

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc),
    .opnd    (opnd),
    .low_bit (step_low),
    .is_div  (is_div),
    .acc_nxt (step_acc),
    .bit_out (step_bit)
  );

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    acc_nxt    = acc;
    low_nxt    = low;
    opnd_nxt   = opnd;
    is_div_nxt = is_div;
    neg_q_nxt  = neg_q;
    neg_r_nxt  = neg_r;
    hi_nxt     = hi;
    lo_nxt     = lo;
    done_nxt   = 1'b0;

    signed_op = (op == OP_MULT) || (op == OP_DIV);
    op_div    = (op == OP_DIV) || (op == OP_DIVU);
    a_abs     = (signed_op && A[WIDTH-1]) ? -A : A;
    b_abs     = (signed_op && B[WIDTH-1]) ? -B : B;
`ifdef MULDIV_FAST_MUL_EN
    prod      = {{WIDTH{1'b0}}, a_abs} * {{WIDTH{1'b0}}, b_abs};
`endif
    prod_fix  = neg_q ? -{acc, low} : {acc, low};
    q_fix     = neg_q ? -low : low;
    r_fix     = neg_r ? -acc : acc;

    case (state)
      ST_IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              is_div_nxt = op_div;
              // Divide-by-zero keeps an all-ones quotient, so never negate it.
              neg_q_nxt  = signed_op && (A[WIDTH-1] ^ B[WIDTH-1]) &&
                           !(op_div && (B == '0));
              neg_r_nxt  = signed_op && A[WIDTH-1];
              acc_nxt    = '0;
              low_nxt    = op_div ? a_abs : b_abs;
              opnd_nxt   = op_div ? b_abs : a_abs;
              cnt_nxt    = CNT_W'(WIDTH);
              state_nxt  = ST_RUN;
`ifdef MULDIV_FAST_MUL_EN
              if (!op_div) begin
                {acc_nxt, low_nxt} = prod;
                state_nxt          = ST_FIX;
              end
`endif
            end
            OP_MTHI: begin
              hi_nxt   = A;
              done_nxt = 1'b1;
            end
            OP_MTLO: begin
              lo_nxt   = A;
              done_nxt = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_nxt = ST_IDLE;
        end else begin
          acc_nxt = step_acc;
          low_nxt = is_div ? {low[WIDTH-2:0], step_bit} : {step_bit, low[WIDTH-1:1]};
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_nxt = ST_FIX;
        end
      end
      ST_FIX: begin
        state_nxt = ST_IDLE;
        if (!flush) begin
          done_nxt = 1'b1;
          if (is_div) begin
            hi_nxt = r_fix;
            lo_nxt = q_fix;
          end else begin
            {hi_nxt, lo_nxt} = prod_fix;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      acc    <= '0;
      low    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      acc    <= acc_nxt;
      low    <= low_nxt;
      opnd   <= opnd_nxt;
      is_div <= is_div_nxt;
      neg_q  <= neg_q_nxt;
      neg_r  <= neg_r_nxt;
      hi     <= hi_nxt;
      lo     <= lo_nxt;
      done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed check of muldiv_unit against an arithmetic model.
module tb_muldiv_unit;

  logic        clk, rst, start, flush, busy, done;
  logic [2:0]  op;
  logic [31:0] A, B, hi, lo;
  logic [31:0] hi_m, lo_m;
  int          tests, fails;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {hi, lo} after op o, given the current {hi, lo}.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    case (o)
      3'd0: return sa * sb;
      3'd1: return ua * ub;
      3'd2, 3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o == 3'd2) begin
          q = sa / sb;
          r = sa % sb;
        end else begin
          q = longint'(ua / ub);
          r = longint'(ua % ub);
        end
        return {r[31:0], q[31:0]};
      end
      3'd4: return {a, cur[31:0]};
      3'd5: return {cur[63:32], a};
      default: return cur;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int          n, nbusy, lat;
    exp = model(o, a, b, {hi_m, lo_m});
    lat = (o >= 3'd4) ? 0 : 33;
`ifdef MULDIV_FAST_MUL_EN
    if (o <= 3'd1) lat = 1;
`endif
    @(negedge clk);
    op = o; A = a; B = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (o < 3'd4) check({tag, "_done_clear"}, done, 0);
    n = 0;
    nbusy = 0;
    while (!done && n < 100) begin
      if (busy) nbusy++;
      @(posedge clk);
      #1 n++;
    end
    if (busy) nbusy++;
    check({tag, "_latency"}, n, lat);
    check({tag, "_busy_cycles"}, nbusy, lat);
    check({tag, "_hi"}, hi, exp[63:32]);
    check({tag, "_lo"}, lo, exp[31:0]);
    hi_m = exp[63:32];
    lo_m = exp[31:0];
  endtask

  initial begin
    int ndone;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    tests = 0; fails = 0;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; A = '0; B = '0;
    hi_m = '0; lo_m = '0;
    #1;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_hi_const", hi, 64'hFFFF_FFFE);
    check("multu_max_lo_const", lo, 64'h1);
    run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5);
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_lo_const", lo, 64'hFFFF_FFFD);
    run_op("divu_zero", 3'd3, 32'h7, 32'd0);
    run_op("div_zero_neg", 3'd2, 32'hFFFF_FF00, 32'd0);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mthi", 3'd4, 32'hCAFE_F00D, 32'd0);
    run_op("mtlo", 3'd5, 32'h1234, 32'd0);

    // Start during an operation is dropped.
    @(negedge clk);
    op = 3'd3; A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    op = 3'd0; A = 32'd9; B = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    while (!done && ndone < 100) begin
      @(posedge clk);
      #1 ndone++;
    end
    check("ignored_start_done", done, 1);
    check("ignored_start_lo", lo, 14);
    check("ignored_start_hi", hi, 2);
    hi_m = 32'd2; lo_m = 32'd14;
    run_op("mtlo2", 3'd5, 32'h1234, 32'd0);

    // Flush during RUN.
    @(negedge clk);
    op = 3'd3; A = 32'd50; B = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_run_busy", busy, 0);
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done) ndone++;
    end
    check("flush_run_nodone", ndone, 0);
    check("flush_run_lo", lo, lo_m);
    check("flush_run_hi", hi, hi_m);

    // Flush on the FIX edge.
    @(negedge clk);
    op = 3'd1; A = 32'd11; B = 32'd13; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (32) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_fix_done", done, 0);
    check("flush_fix_busy", busy, 0);
    check("flush_fix_lo", lo, lo_m);

    // Start together with flush in IDLE, and an undefined op.
    @(negedge clk);
    op = 3'd4; A = 32'h5555_AAAA; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 begin start = 1'b0; flush = 1'b0; end
    check("start_flush_hi", hi, hi_m);
    check("start_flush_done", done, 0);
    @(negedge clk);
    op = 3'd6; A = 32'h1; B = 32'h2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("op6_busy", busy, 0);
    check("op6_done", done, 0);
    check("op6_lo", lo, lo_m);

    // Randomized ops, with divide-by-zero and overflow corners mixed in.
    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom_range(0, 5));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb);
    end

    // Asynchronous reset mid-operation.
    @(negedge clk);
    op = 3'd2; A = 32'd1000; B = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    hi_m = '0; lo_m = '0;
    run_op("post_rst_div", 3'd2, 32'hFFFF_FC18, 32'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit for the EX stage of the MIPS pipeline, operating beside the combinational ALU. It executes MULT/MULTU/DIV/DIVU iteratively (one bit per cycle) and owns the architectural HI/LO registers, including MTHI/MTLO writes. A start/busy/done handshake lets the hazard unit stall MFHI/MFLO and further mul/div ops while an operation is in flight.

## Interface
- WIDTH, 32: operand and HI/LO width; must be ≥ 4 and even.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only when busy=0.
- op  input  3  operation: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6–7 ignored (no effect, no done).
- A  input  WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO data).
- B  input  WIDTH  rt operand (divisor / multiplier).
- flush  input  1  abort the in-flight op (branch mispredict or exception).
- busy  output  1  op in progress; reset 0.
- done  output  1  one-cycle pulse when HI/LO is updated; reset 0.
- hi  output  WIDTH  HI register; reset 0.
- lo  output  WIDTH  LO register; reset 0.

## Operation
- States:
  - IDLE: start && valid op && !flush. MUL/DIV latches |A| and |B| for signed ops (raw values for unsigned), records the result sign and the remainder sign (= sign of A), clears the accumulator, loads count = WIDTH, then goes to RUN. MTHI/MTLO writes hi/lo directly and stays in IDLE.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, decrementing count; moves to FIX when count reaches 1 on that edge.
  - FIX: conditionally two's-complement-negates the product (2·WIDTH bits), quotient and remainder, writes hi/lo, pulses done, and returns to IDLE.
- Multiply: {hi,lo} = full 2·WIDTH-bit product.
- Divide: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- Divide by zero (B=0), signed or unsigned: lo = all ones, hi = A. The result is still produced after the full latency.
- Signed overflow (A = most-negative, B = all ones): lo = A, hi = 0.
- start while busy=1: ignored, with no queueing.
- flush in RUN/FIX: returns to IDLE at the next edge; hi/lo unchanged; no done. flush in IDLE suppresses that cycle's start.
- start and flush in the same cycle: flush wins.
- rst at any time: all state and outputs go to their reset values immediately; an in-flight op is lost.

## Timing
- MUL/DIV accepted at edge T0; busy=1 after T0.
- WIDTH RUN edges (T1..T_WIDTH), then the FIX edge T_WIDTH+1, which updates hi/lo, sets done=1 and busy=0. done lasts exactly one cycle.
- Total latency is WIDTH+1 cycles, which is 33 for WIDTH=32. A new start is accepted in the same cycle done=1.
- MTHI/MTLO: hi/lo are updated at T0, done=1 during the cycle after T0, and busy stays 0.
- busy is registered only; there is no combinational path from start to busy.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - MULT/MULTU use a single-cycle `*` product: IDLE→FIX directly, so hi/lo and done arrive at T1 (latency 1), with busy=1 for one cycle.
  - Divide timing is unchanged.
- Undefined: all MUL/DIV ops are iterative with latency WIDTH+1.

## Structure
- Package muldiv_pkg holds:
  - the op encodings (OP_MULT … OP_MTLO);
  - the state enum (ST_IDLE, ST_RUN, ST_FIX);
  - a CNT_W = $clog2(WIDTH+1) helper.
- One sub-module, muldiv_step: the combinational single-iteration datapath. It takes the accumulator, operand and mode and returns the next accumulator and quotient bit. The FSM, counter and HI/LO registers stay in muldiv_unit.

## Test plan
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 cycles after acceptance; busy high for 33 cycles.
- MULT A=0xFFFFFFFD (−3), B=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV A=0xFFFFFFF9 (−7), B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU A=0x7, B=0 → lo=0xFFFFFFFF, hi=0x7.
- DIV A=0x80000000, B=0xFFFFFFFF → lo=0x80000000, hi=0.
- Control sequence:
  1. MTLO 0x1234 → lo=0x1234 next edge, done one cycle later.
  2. DIVU started; a second start with op=MULT asserted mid-op → ignored.
  3. flush asserted at cycle 10 → busy=0 next cycle, lo still 0x1234, no done.
  4. rst pulsed mid-op → hi=lo=0, busy=done=0 immediately.
